aux_uart_tx: RTL and testbench

//   Auxiliary UART transmitter: the transmit end of the aux UART link whose receive end boots the MCU.

---
 rtl/aux_uart_tx.sv | 159 +++++++++++++++
 tb/tb_aux_uart_tx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/aux_uart_tx.sv
// Auxiliary UART transmitter: FIFO-buffered bytes serialised as 8N1 at a fixed baud rate.
// Frames are sent back-to-back while the FIFO holds data; tx idles high.
module aux_uart_tx #(
  parameter int unsigned CLK_FREQUENCY = 50_000_000,
  parameter int unsigned BAUD_RATE     = 115_200,
  parameter int unsigned FIFO_DEPTH    = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          i_wr_valid,
  input  logic [7:0]                    i_wr_data,
  output logic                          o_wr_ready,
  output logic                          o_overflow,
  input  logic                          i_overflow_clr,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_busy,
  output logic                          o_tx
);

  localparam int unsigned DIV   = CLK_FREQUENCY / BAUD_RATE;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = AW + 1;

  if (DIV < 2) begin : g_bad_div
    $error("aux_uart_tx: CLK_FREQUENCY / BAUD_RATE must be at least 2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("aux_uart_tx: FIFO_DEPTH must be a power of 2 and at least 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  state_t           r_state;
  logic [CNT_W-1:0] r_baud_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_tx;

  logic             w_wr_ready;
  logic             w_push;
  logic             w_pop;
  logic             w_baud_end;
  logic [7:0]       w_head;

  assign w_wr_ready = (r_count != CW'(FIFO_DEPTH));
  assign w_push     = i_wr_valid && w_wr_ready;
  assign w_baud_end = (r_baud_cnt == CNT_W'(DIV - 1));
  assign w_head     = r_mem[r_rd_ptr];
  // The FSM takes the head byte either from idle or at the end of a stop bit.
  assign w_pop      = (r_count != CW'(0)) &&
                      ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_end));

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Set has priority over clear so a rejected byte is never hidden.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else if (i_wr_valid && !w_wr_ready) begin
      r_overflow <= 1'b1;
    end else if (i_overflow_clr) begin
      r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_tx       <= 1'b1;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_shift    <= w_head;
            r_tx       <= 1'b0;
            r_baud_cnt <= '0;
            r_state    <= S_START;
          end
        end
        S_START: begin
          if (w_baud_end) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_tx       <= r_shift[0];
            r_state    <= S_DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (w_baud_end) begin
            r_baud_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx      <= r_shift[r_bit_idx + 3'd1];
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (w_baud_end) begin
            r_baud_cnt <= '0;
            if (w_pop) begin
              r_shift <= w_head;
              r_tx    <= 1'b0;
              r_state <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_wr_ready   = w_wr_ready;
  assign o_overflow   = r_overflow;
  assign o_fifo_count = r_count;
  assign o_busy       = (r_state != S_IDLE) || (r_count != CW'(0));
  assign o_tx         = r_tx;

endmodule

// File: tb/tb_aux_uart_tx.sv
// Directed bench for aux_uart_tx with DIV = 10 and a 4-entry FIFO.
// Frame tables hold hand-derived line slots in time order: start, d0..d7, stop.
module tb_aux_uart_tx;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       i_wr_valid;
  logic [7:0] i_wr_data;
  logic       o_wr_ready;
  logic       o_overflow;
  logic       i_overflow_clr;
  logic [2:0] o_fifo_count;
  logic       o_busy;
  logic       o_tx;

  int n_cmp = 0;
  int n_err = 0;

  aux_uart_tx #(
    .CLK_FREQUENCY (1000),
    .BAUD_RATE     (100),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_wr_valid     (i_wr_valid),
    .i_wr_data      (i_wr_data),
    .o_wr_ready     (o_wr_ready),
    .o_overflow     (o_overflow),
    .i_overflow_clr (i_overflow_clr),
    .o_fifo_count   (o_fifo_count),
    .o_busy         (o_busy),
    .o_tx           (o_tx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [0:9] slots;
    string      name;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after the edge that drives the start bit; returns at the
  // same phase one frame later, optionally pushing a byte on that boundary edge.
  task automatic expect_frame(input logic [0:9] slots, input string nm,
                              input logic do_push, input logic [7:0] pd);
    chk({nm, "_start_edge"}, 32'(o_tx), 32'(0));
    tick(5);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("%s_slot%0d", nm, i), 32'(o_tx), 32'(slots[i]));
      if (i == 5) chk({nm, "_busy_mid"}, 32'(o_busy), 32'(1));
      if (i < 9) tick(10);
    end
    tick(4);
    chk({nm, "_stop_last"}, 32'(o_tx), 32'(1));
    chk({nm, "_busy_last"}, 32'(o_busy), 32'(1));
    if (do_push) begin
      i_wr_valid = 1'b1;
      i_wr_data  = pd;
    end
    tick(1);
    i_wr_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs [3];
    logic [7:0] ovf_bytes [6];
    vecs[0] = '{8'hA5, 10'b0101001011, "a5"};
    vecs[1] = '{8'h3C, 10'b0001111001, "3c"};
    vecs[2] = '{8'hC3, 10'b0110000111, "c3"};
    ovf_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    reset_n        = 1'b0;
    i_wr_valid     = 1'b0;
    i_wr_data      = 8'h00;
    i_overflow_clr = 1'b0;
    tick(3);
    chk("rst_tx",       32'(o_tx),         32'(1));
    chk("rst_count",    32'(o_fifo_count), 32'(0));
    chk("rst_ready",    32'(o_wr_ready),   32'(1));
    chk("rst_overflow", 32'(o_overflow),   32'(0));
    chk("rst_busy",     32'(o_busy),       32'(0));
    reset_n = 1'b1;
    tick(3);

    // Single frames from idle: 2-cycle latency, exact bit pattern, busy drop.
    for (int v = 0; v < 3; v++) begin
      i_wr_valid = 1'b1;
      i_wr_data  = vecs[v].data;
      tick(1);
      i_wr_valid = 1'b0;
      chk({vecs[v].name, "_tx_after_push"},   32'(o_tx),         32'(1));
      chk({vecs[v].name, "_busy_after_push"}, 32'(o_busy),       32'(1));
      chk({vecs[v].name, "_count_queued"},    32'(o_fifo_count), 32'(1));
      tick(1);
      chk({vecs[v].name, "_count_popped"},    32'(o_fifo_count), 32'(0));
      expect_frame(vecs[v].slots, vecs[v].name, 1'b0, 8'h00);
      chk({vecs[v].name, "_busy_end"}, 32'(o_busy), 32'(0));
      chk({vecs[v].name, "_tx_idle"},  32'(o_tx),   32'(1));
      tick(4);
    end

    // Back-to-back 00/FF, then a push on the stop-to-start pop edge.
    i_wr_valid = 1'b1;
    i_wr_data  = 8'h00;
    tick(1);
    i_wr_data  = 8'hFF;
    tick(1);
    i_wr_valid = 1'b0;
    chk("b2b_count_push_pop", 32'(o_fifo_count), 32'(1));
    expect_frame(10'b0000000001, "b2b_00", 1'b1, 8'h5A);
    chk("drain_count_push_pop", 32'(o_fifo_count), 32'(1));
    expect_frame(10'b0111111111, "b2b_ff", 1'b0, 8'h00);
    chk("drain_count_last", 32'(o_fifo_count), 32'(0));
    expect_frame(10'b0010110101, "drain_5a", 1'b0, 8'h00);
    chk("drain_busy_end", 32'(o_busy), 32'(0));
    tick(4);

    // Overflow while a frame is on the line.
    i_wr_valid = 1'b1;
    i_wr_data  = 8'hC3;
    tick(1);
    i_wr_valid = 1'b0;
    tick(1);
    chk("ovf_frame_started", 32'(o_tx), 32'(0));
    for (int i = 0; i < 6; i++) begin
      i_wr_valid = 1'b1;
      i_wr_data  = ovf_bytes[i];
      tick(1);
      if (i == 2) chk("ovf_ready_at3", 32'(o_wr_ready), 32'(1));
      if (i == 3) begin
        chk("ovf_ready_full", 32'(o_wr_ready),   32'(0));
        chk("ovf_count_full", 32'(o_fifo_count), 32'(4));
        chk("ovf_not_yet",    32'(o_overflow),   32'(0));
      end
      if (i == 4) chk("ovf_set", 32'(o_overflow), 32'(1));
    end
    i_wr_valid = 1'b0;
    chk("ovf_count_kept", 32'(o_fifo_count), 32'(4));
    i_overflow_clr = 1'b0;
    tick(1);
    i_wr_valid     = 1'b1;
    i_wr_data      = 8'h77;
    i_overflow_clr = 1'b1;
    tick(1);
    i_wr_valid     = 1'b0;
    i_overflow_clr = 1'b0;
    chk("ovf_set_wins", 32'(o_overflow), 32'(1));
    i_overflow_clr = 1'b1;
    tick(1);
    i_overflow_clr = 1'b0;
    chk("ovf_cleared", 32'(o_overflow), 32'(0));
    tick(91);
    expect_frame(10'b0100010001, "ovf_11", 1'b0, 8'h00);
    expect_frame(10'b0010001001, "ovf_22", 1'b0, 8'h00);
    expect_frame(10'b0110011001, "ovf_33", 1'b0, 8'h00);
    expect_frame(10'b0001000101, "ovf_44", 1'b0, 8'h00);
    chk("ovf_busy_end",  32'(o_busy),       32'(0));
    chk("ovf_count_end", 32'(o_fifo_count), 32'(0));
    for (int i = 0; i < 3; i++) begin
      tick(10);
      chk($sformatf("ovf_no_extra_%0d", i), 32'(o_tx), 32'(1));
    end

    // Asynchronous reset in the middle of the data bits.
    i_wr_valid = 1'b1;
    i_wr_data  = 8'hA5;
    tick(1);
    i_wr_data  = 8'h5A;
    tick(1);
    i_wr_valid = 1'b0;
    tick(30);
    chk("rstmid_in_frame", 32'(o_busy), 32'(1));
    #2 reset_n = 1'b0;
    #1;
    chk("rstmid_tx",    32'(o_tx),         32'(1));
    chk("rstmid_count", 32'(o_fifo_count), 32'(0));
    chk("rstmid_busy",  32'(o_busy),       32'(0));
    chk("rstmid_ready", 32'(o_wr_ready),   32'(1));
    tick(2);
    #2 reset_n = 1'b1;
    tick(3);
    chk("rstmid_stays_idle", 32'(o_tx), 32'(1));
    i_wr_valid = 1'b1;
    i_wr_data  = 8'h3C;
    tick(1);
    i_wr_valid = 1'b0;
    chk("rstmid_3c_latency", 32'(o_tx), 32'(1));
    tick(1);
    expect_frame(10'b0001111001, "rstmid_3c", 1'b0, 8'h00);
    chk("rstmid_3c_busy_end", 32'(o_busy), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
